// File: rtl/vga_scroll_pattern.sv
// Scrolling test-pattern generator: per-frame scroll offset with four patterns.
// Define VGA_SCROLL_PINGPONG_EN for bouncing scroll; default build wraps around.
module vga_scroll_pattern #(
  parameter int COLOR_BITS = 2,
  parameter int OFFSET_W   = 8,
  parameter int TILE_LOG2  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  display_on,
  input  logic                  vsync,
  input  logic [1:0]            mode,
  input  logic [3:0]            speed,
  input  logic                  pause,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  frame_tick,
  output logic [OFFSET_W-1:0]   offset,
  output logic                  dir
);

  logic                  vsync_d;
  logic [1:0]            mode_lat;
  logic [OFFSET_W-1:0]   offset_nxt;
  logic                  dir_nxt;
  logic [9:0]            x_eff_p0;
  logic [9:0]            y_eff_p0;
  logic                  pat_bit_p0;
  logic [COLOR_BITS-1:0] r_p0;
  logic [COLOR_BITS-1:0] g_p0;
  logic [COLOR_BITS-1:0] b_p0;

`ifdef VGA_SCROLL_PINGPONG_EN
  localparam logic [11:0] OFF_MAX = 12'((1 << OFFSET_W) - 1);

  // Forward step saturating at the top of the range; MSB of result is the new dir.
  function automatic logic [OFFSET_W:0] fwd_step(input logic [OFFSET_W-1:0] off,
                                                 input logic [3:0] spd);
    logic [11:0] sum;
    sum = 12'(off) + 12'(spd);
    if (sum >= OFF_MAX) fwd_step = {1'b1, OFFSET_W'(OFF_MAX)};
    else                fwd_step = {1'b0, OFFSET_W'(sum)};
  endfunction

  function automatic logic [OFFSET_W:0] rev_step(input logic [OFFSET_W-1:0] off,
                                                 input logic [3:0] spd);
    if (12'(off) <= 12'(spd)) rev_step = {1'b0, {OFFSET_W{1'b0}}};
    else                      rev_step = {1'b1, OFFSET_W'(12'(off) - 12'(spd))};
  endfunction
`endif

  function automatic logic tile_bit(input logic [9:0] v);
    tile_bit = v[TILE_LOG2];
  endfunction

  function automatic logic [COLOR_BITS-1:0] top_bits(input logic [9:0] v);
    top_bits = v[9 -: COLOR_BITS];
  endfunction

  always_comb begin
    offset_nxt = offset;
    dir_nxt    = dir;
    if (!(pause || speed == 4'd0)) begin
`ifdef VGA_SCROLL_PINGPONG_EN
      if (!dir) {dir_nxt, offset_nxt} = fwd_step(offset, speed);
      else      {dir_nxt, offset_nxt} = rev_step(offset, speed);
`else
      offset_nxt = OFFSET_W'(12'(offset) + 12'(speed));
`endif
    end
  end

  // Frame control: vsync is only ever sampled, never used as a clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
      offset     <= '0;
      dir        <= 1'b0;
      mode_lat   <= 2'd0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= vsync & ~vsync_d;
      if (frame_tick) begin
        offset   <= offset_nxt;
        dir      <= dir_nxt;
        mode_lat <= mode;
      end
    end
  end

  // Stage p0: scrolled coordinates and pattern selection
  assign x_eff_p0 = hpos + 10'(offset);
  assign y_eff_p0 = vpos + 10'(offset);

  always_comb begin
    pat_bit_p0 = 1'b0;
    r_p0       = '0;
    g_p0       = '0;
    b_p0       = '0;
    case (mode_lat)
      2'd0: pat_bit_p0 = tile_bit(x_eff_p0);
      2'd1: pat_bit_p0 = tile_bit(x_eff_p0) ^ tile_bit(y_eff_p0);
      2'd2: pat_bit_p0 = tile_bit(y_eff_p0);
      default: pat_bit_p0 = 1'b0;
    endcase
    if (mode_lat == 2'd3) begin
      r_p0 = top_bits(x_eff_p0);
      g_p0 = top_bits(vpos);
      b_p0 = offset[OFFSET_W-1 -: COLOR_BITS];
    end else begin
      r_p0 = {COLOR_BITS{pat_bit_p0}};
      g_p0 = {COLOR_BITS{pat_bit_p0}};
      b_p0 = {COLOR_BITS{pat_bit_p0}};
    end
    if (!display_on) begin
      r_p0 = '0;
      g_p0 = '0;
      b_p0 = '0;
    end
  end

  // Stage p1: registered colour outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= r_p0;
      g <= g_p0;
      b <= b_p0;
    end
  end

endmodule

// File: tb/tb_vga_scroll_pattern.sv
// Testbench for vga_scroll_pattern: directed scenarios plus randomized frames
// checked against an arithmetic model of offset, direction and pixel colour.
module tb_vga_scroll_pattern;

  localparam int CB = 2;
  localparam int OW = 8;
  localparam int TL = 5;
  localparam int OMAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [9:0]    hpos = '0;
  logic [9:0]    vpos = '0;
  logic          display_on = 1'b0;
  logic          vsync = 1'b0;
  logic [1:0]    mode = '0;
  logic [3:0]    speed = '0;
  logic          pause = 1'b0;
  logic [CB-1:0] r, g, b;
  logic          frame_tick;
  logic [OW-1:0] offset;
  logic          dir;

  vga_scroll_pattern #(.COLOR_BITS(CB), .OFFSET_W(OW), .TILE_LOG2(TL)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .vsync(vsync), .mode(mode), .speed(speed), .pause(pause),
    .r(r), .g(g), .b(b), .frame_tick(frame_tick), .offset(offset), .dir(dir)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  int m_off = 0;
  int m_dir = 0;
  int m_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    int s;
    s = int'(speed);
    m_mode = int'(mode);
    if (pause || s == 0) return;
`ifdef VGA_SCROLL_PINGPONG_EN
    if (m_dir == 0) begin
      if (m_off + s >= OMAX) begin m_off = OMAX; m_dir = 1; end
      else m_off = m_off + s;
    end else begin
      if (m_off <= s) begin m_off = 0; m_dir = 0; end
      else m_off = m_off - s;
    end
`else
    m_off = (m_off + s) % (OMAX + 1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    m_off = 0; m_dir = 0; m_mode = 0;
    chk("rst_offset", 32'(offset), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_rgb", 32'({r, g, b}), 0);
    reset = 1'b0;
  endtask

  // One vsync pulse: tick must be high exactly one cycle, then state updates.
  task automatic tick();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    chk("tick_high", 32'(frame_tick), 1);
    model_tick();
    @(negedge clk);
    chk("tick_low", 32'(frame_tick), 0);
    chk("tick_offset", 32'(offset), 32'(m_off));
    chk("tick_dir", 32'(dir), 32'(m_dir));
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic pix(input int h, input int v, input bit d);
    int x, y, xb, yb, full, pb;
    logic [31:0] er, eg, eb;
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); display_on = d;
    @(posedge clk);
    #1;
    x = (h + m_off) % 1024;
    y = (v + m_off) % 1024;
    xb = (x >> TL) & 1;
    yb = (y >> TL) & 1;
    full = (1 << CB) - 1;
    case (m_mode)
      0: pb = xb;
      1: pb = xb ^ yb;
      2: pb = yb;
      default: pb = 0;
    endcase
    if (m_mode == 3) begin
      er = 32'(x >> (10 - CB));
      eg = 32'(v >> (10 - CB));
      eb = 32'(m_off >> (OW - CB));
    end else begin
      er = pb ? 32'(full) : 0;
      eg = er;
      eb = er;
    end
    if (!d) begin er = 0; eg = 0; eb = 0; end
    chk("pix_r", 32'(r), er);
    chk("pix_g", 32'(g), eg);
    chk("pix_b", 32'(b), eb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved;

    // Reset and a single tick at speed 4
    do_reset();
    speed = 4'd4; pause = 1'b0; mode = 2'd0;
    tick();
    chk("first_tick_offset", 32'(offset), 4);
    chk("first_tick_dir", 32'(dir), 0);

    // Mode change mid-frame only takes effect at the next tick
    do_reset();
    mode = 2'd1;
    pix(32, 0, 1'b1);
    chk("mode0_hold", 32'(r), 3);
    pix(0, 32, 1'b1);
    chk("mode0_still", 32'(r), 0);
    speed = 4'd0;
    tick();
    pix(32, 0, 1'b1);
    chk("mode1_after", 32'({r, g, b}), 32'(6'b111111));
    pix(0, 32, 1'b1);
    pix(32, 0, 1'b0);
    chk("blank", 32'({r, g, b}), 0);

    // Range boundaries
    do_reset();
    mode = 2'd0;
`ifdef VGA_SCROLL_PINGPONG_EN
    speed = 4'd4;
    for (int i = 0; i < 63; i++) tick();
    chk("reach_252", 32'(offset), 252);
    tick();
    chk("sat_top", 32'(offset), 255);
    chk("sat_dir", 32'(dir), 1);
    tick();
    chk("rev_step", 32'(offset), 251);
    speed = 4'd8;
    for (int i = 0; i < 31; i++) tick();
    chk("reach_3", 32'(offset), 3);
    speed = 4'd5;
    tick();
    chk("floor_offset", 32'(offset), 0);
    chk("floor_dir", 32'(dir), 0);
`else
    speed = 4'd15;
    for (int i = 0; i < 16; i++) tick();
    speed = 4'd14;
    tick();
    chk("reach_254", 32'(offset), 254);
    speed = 4'd3;
    tick();
    chk("wrap_offset", 32'(offset), 1);
    chk("wrap_dir", 32'(dir), 0);
`endif

    // Reset release with vsync already high, then paused ticks
    vsync = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_false_tick", 32'(frame_tick), 0);
    end
    vsync = 1'b0;
    @(negedge clk);
    speed = 4'd7;
    tick();
    saved = m_off;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("pause_hold", 32'(offset), 32'(saved));
    pause = 1'b0;

    // Randomized frames and pixels
    for (int i = 0; i < 60; i++) begin
      mode  = 2'($urandom_range(0, 3));
      speed = 4'($urandom_range(0, 15));
      pause = ($urandom_range(0, 3) == 0);
      tick();
      for (int j = 0; j < 3; j++)
        pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            $urandom_range(0, 4) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
